// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter and its request front-end.
//   NUM_PORTS     : number of requesters seen by the arbiter
//   PORT_W        : width of a port index
//   port_vec_t    : one bit per port (req / gnt vectors)
//   port_idx_t    : encoded port index
//   onehot_to_idx : one-hot port vector -> encoded index
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);

    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [PORT_W-1:0]    port_idx_t;

    // OR-reduce the indices of all set bits; exact for a one-hot input.
    function automatic port_idx_t onehot_to_idx(input port_vec_t oh);
        port_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = idx | port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_port_fifo.sv
// -----------------------------------------------------------------------------
// arb_port_fifo
// Single-port synchronous FIFO, DEPTH x DATA_W, with a sticky overflow flag.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write strobe; dropped (and ovf_o set) when full
//   pop_i      : read strobe; ignored when empty
//   wdata_i    : write payload
//   rdata_o    : head entry (combinational)
//   count_o    : occupancy, 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
//   ovf_o      : sticky, a push was dropped
// -----------------------------------------------------------------------------
module arb_port_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q;
    logic              push_ok, pop_ok;

    // Fullness is judged on the registered count, so a push into a full
    // FIFO is dropped even if the same cycle pops it.
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)           rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_i && full_o) ovf_q    <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy tracking makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/arb_req_buffer.sv
// -----------------------------------------------------------------------------
// arb_req_buffer
// Request front-end for the round-robin arbiter: per-port FIFOs drive req_o,
// the arbiter's one-hot grant pops the granted head into a registered
// valid/ready output stage tagged with the source port.
//   clk, reset   : clock, synchronous active-high reset
//   push_i       : per-port write strobe
//   push_data_i  : per-port payload, port i at [i*DATA_W +: DATA_W]
//   full_o       : per-port FIFO full
//   req_o        : request vector to the arbiter
//   gnt_i        : one-hot grant from the arbiter (same cycle as req_o)
//   out_valid_o  : output register holds a payload
//   out_data_o   : granted payload
//   out_port_o   : port that produced out_data_o
//   out_ready_i  : downstream accept
//   ovf_o        : sticky per-port dropped push
//   err_o        : sticky illegal grant (multi-hot or unrequested)
// -----------------------------------------------------------------------------
module arb_req_buffer #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          push_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   push_data_i,
    output logic [NUM_PORTS-1:0]          full_o,
    output logic [NUM_PORTS-1:0]          req_o,
    input  logic [NUM_PORTS-1:0]          gnt_i,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(NUM_PORTS)-1:0]  out_port_o,
    input  logic                          out_ready_i,
    output logic [NUM_PORTS-1:0]          ovf_o,
    output logic                          err_o
);

    import arb_pkg::*;

    localparam int PW    = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]    head_w  [NUM_PORTS];
    logic [CNT_W-1:0]     count_w [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty_w, pop_w;

    logic                 stall;
    logic                 gnt_onehot, gnt_legal, gnt_illegal;
    logic [PW-1:0]        gnt_idx;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [PW-1:0]        out_port_q,  out_port_d;
    logic                 err_q,       err_d;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        arb_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_i[g]),
            .pop_i   (pop_w[g]),
            .wdata_i (push_data_i[g*DATA_W +: DATA_W]),
            .rdata_o (head_w[g]),
            .count_o (count_w[g]),
            .full_o  (full_o[g]),
            .empty_o (empty_w[g]),
            .ovf_o   (ovf_o[g])
        );
    end

    // Requests are withdrawn while the output is stalled, so any grant the
    // arbiter returns can always be loaded into the output register.
    assign stall = out_valid_q & ~out_ready_i;

    always_comb begin
        req_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_o[i] = (count_w[i] != '0) & ~stall;
        end
    end

    assign gnt_onehot  = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
    assign gnt_legal   = gnt_onehot && ((gnt_i & req_o) != '0);
    assign gnt_illegal = (gnt_i != '0) && !gnt_legal;
    assign gnt_idx     = PW'(onehot_to_idx(gnt_i));
    assign pop_w       = gnt_legal ? (gnt_i & ~empty_w) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        err_d       = err_q | gnt_illegal;
        if (gnt_legal) begin
            out_valid_d = 1'b1;
            out_data_d  = head_w[gnt_idx];
            out_port_d  = gnt_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_port_o  = out_port_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_arb_req_buffer.sv
module tb_arb_req_buffer;

    localparam int NP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] push_i;
    logic [NP*DW-1:0] push_data_i;
    logic [NP-1:0] full_o, req_o, gnt_i, ovf_o;
    logic          out_valid_o, out_ready_i, err_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_port_o;

    int checks = 0;
    int errors = 0;

    // Expected payloads per port, pushed when stimulus is accepted.
    logic [DW-1:0] exp_q [NP][$];
    int            xfer_cnt;

    // Grant source: 0 = manual, 1 = req_o & mask, 2 = round-robin model.
    int            mode;
    logic [NP-1:0] gnt_man, gnt_mask, gnt_rr;
    int            rr_last;
    logic          found;

    always #5 clk = ~clk;

    arb_req_buffer #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_port_o  (out_port_o),
        .out_ready_i (out_ready_i),
        .ovf_o       (ovf_o),
        .err_o       (err_o)
    );

    always_comb begin
        gnt_rr = '0;
        found  = 1'b0;
        for (int k = 1; k <= NP; k++) begin
            if (!found && req_o[(rr_last + k) % NP]) begin
                gnt_rr[(rr_last + k) % NP] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (mode)
            1:       gnt_i = req_o & gnt_mask;
            2:       gnt_i = gnt_rr;
            default: gnt_i = gnt_man;
        endcase
    end

    always @(posedge clk) begin
        if (reset) rr_last <= NP - 1;
        else if (mode == 2) begin
            for (int k = 0; k < NP; k++) if (gnt_i[k]) rr_last <= k;
        end
    end

    // Scoreboard: every accepted transfer must match the head of its port queue.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (out_valid_o && out_ready_i) begin
            checks++;
            xfer_cnt++;
            if (exp_q[out_port_o].size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected port=%0d got=%h expected=none", out_port_o, out_data_o);
            end else begin
                e = exp_q[out_port_o].pop_front();
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL sb_data port=%0d got=%h expected=%h", out_port_o, out_data_o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [NP-1:0] m, input logic [NP*DW-1:0] d,
                              input logic [NP-1:0] accept);
        push_i      = m;
        push_data_i = d;
        for (int i = 0; i < NP; i++)
            if (m[i] && accept[i]) exp_q[i].push_back(d[i*DW +: DW]);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NP; i++) if (exp_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pending() || out_valid_o) && n < budget);
        checks++;
        if (pending() || out_valid_o) begin
            errors++;
            $display("FAIL %s_drain_timeout got=pending expected=drained", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; push_i = 4'b1111; push_data_i = 32'hDEADBEEF;
        out_ready_i = 1'b1; mode = 0; gnt_man = '0; gnt_mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_o, full_o, ovf_o, err_o, out_valid_o, out_data_o, out_port_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold got=%h expected=0",
                     {req_o, full_o, ovf_o, err_o, out_valid_o, out_data_o, out_port_o});
        end
        step();
        reset = 1'b0; push_i = '0;
        @(negedge clk);
        checks++;
        if ({req_o, full_o, ovf_o, err_o, out_valid_o, out_data_o, out_port_o} !== '0) begin
            errors++;
            $display("FAIL reset_release got=%h expected=0",
                     {req_o, full_o, ovf_o, err_o, out_valid_o, out_data_o, out_port_o});
        end
    endtask

    task automatic test_single();
        mode = 1; gnt_mask = 4'b0001; out_ready_i = 1'b1;
        step();
        drive_push(4'b0001, 32'h000000A5, 4'b0001);
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0000) begin errors++; $display("FAIL single_no_bypass req=%b expected=0000", req_o); end
        step();
        push_i = '0;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0001 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_req req=%b valid=%b expected=0001/0", req_o, out_valid_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_port_o !== 2'd0 || req_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_out valid=%b data=%h port=%0d req=%b expected=1/a5/0/0000",
                     out_valid_o, out_data_o, out_port_o, req_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_clear valid=%b expected=0", out_valid_o); end
    endtask

    task automatic test_full_ovf();
        logic [NP*DW-1:0] d;
        mode = 0; gnt_man = '0; out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            d = '0;
            d[2*DW +: DW] = 8'h10 + 8'(k);
            drive_push(4'b0100, d, (k < 4) ? 4'b0100 : 4'b0000);
            if (k == 3 || k == 4) begin
                @(negedge clk);
                checks++;
                if (full_o !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
                    errors++; $display("FAIL full_after_%0d got=%b", k, full_o);
                end
            end
        end
        step();
        push_i = '0;
        @(negedge clk);
        checks++;
        if (ovf_o !== 4'b0100 || full_o !== 4'b0100) begin
            errors++; $display("FAIL ovf_set ovf=%b full=%b expected=0100/0100", ovf_o, full_o);
        end
        mode = 1; gnt_mask = 4'b0100;
        wait_drain("full", 30);
        repeat (2) @(negedge clk);
        checks++;
        if (full_o !== '0 || req_o !== '0 || ovf_o !== 4'b0100) begin
            errors++; $display("FAIL full_post full=%b req=%b ovf=%b expected=0000/0000/0100", full_o, req_o, ovf_o);
        end
    endtask

    task automatic test_backpressure();
        mode = 0; gnt_man = '0; out_ready_i = 1'b1;
        step();
        drive_push(4'b1101, 32'h33220077, 4'b1101);
        step();
        push_i = '0; out_ready_i = 1'b0; gnt_man = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b1101) begin errors++; $display("FAIL bp_pre req=%b expected=1101", req_o); end
        step();
        gnt_man = '0;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0000 || out_valid_o !== 1'b1 || out_data_o !== 8'h77) begin
            errors++; $display("FAIL bp_stall req=%b valid=%b data=%h expected=0000/1/77", req_o, out_valid_o, out_data_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_data_o !== 8'h77 || req_o !== 4'b0000) begin
            errors++; $display("FAIL bp_hold data=%h req=%b expected=77/0000", out_data_o, req_o);
        end
        step();
        out_ready_i = 1'b1; mode = 2;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b1100) begin errors++; $display("FAIL bp_release req=%b expected=1100", req_o); end
        wait_drain("bp", 30);
    endtask

    task automatic test_illegal_and_reset();
        mode = 0; gnt_man = '0; out_ready_i = 1'b1;
        step();
        drive_push(4'b0011, 32'h00004140, 4'b0011);
        step();
        push_i = '0; gnt_man = 4'b0011;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0011 || err_o !== 1'b0) begin
            errors++; $display("FAIL ill_pre req=%b err=%b expected=0011/0", req_o, err_o);
        end
        step();
        gnt_man = '0;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || req_o !== 4'b0011 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL ill_multihot err=%b req=%b valid=%b expected=1/0011/0", err_o, req_o, out_valid_o);
        end
        // Mid-operation reset discards the two buffered entries.
        step();
        reset = 1'b1;
        for (int i = 0; i < NP; i++) exp_q[i].delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_o !== '0 || err_o !== 1'b0 || ovf_o !== '0 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL midreset req=%b err=%b ovf=%b valid=%b expected=0", req_o, err_o, ovf_o, out_valid_o);
        end
        step();
        drive_push(4'b0001, 32'h00000050, 4'b0001);
        step();
        push_i = '0; gnt_man = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0001 || err_o !== 1'b0) begin
            errors++; $display("FAIL ill_unreq_pre req=%b err=%b expected=0001/0", req_o, err_o);
        end
        step();
        gnt_man = '0;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || req_o !== 4'b0001 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL ill_unreq err=%b req=%b valid=%b expected=1/0001/0", err_o, req_o, out_valid_o);
        end
        mode = 1; gnt_mask = 4'b0001;
        wait_drain("ill", 30);
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] seen;
        mode = 2; out_ready_i = 1'b1; seen = '0;
        step();
        drive_push(4'b1111, 32'h04030201, 4'b1111);
        xfer_cnt = 0;
        step();
        push_i = '0;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b1111 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL rr_req req=%b valid=%b expected=1111/0", req_o, out_valid_o);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (out_valid_o !== 1'b1 || seen[out_port_o] !== 1'b0) begin
                errors++; $display("FAIL rr_beat%0d valid=%b port=%0d seen=%b", c, out_valid_o, out_port_o, seen);
            end
            seen[out_port_o] = 1'b1;
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || seen !== 4'b1111 || xfer_cnt !== 4) begin
            errors++; $display("FAIL rr_end valid=%b seen=%b xfers=%0d expected=0/1111/4", out_valid_o, seen, xfer_cnt);
        end
    endtask

    task automatic test_push_pop_same();
        mode = 0; gnt_man = '0; out_ready_i = 1'b1;
        step(); drive_push(4'b0010, 32'h00006000, 4'b0010);
        step(); drive_push(4'b0010, 32'h00006100, 4'b0010);
        step(); drive_push(4'b0010, 32'h00006200, 4'b0010);
        gnt_man = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_o !== 4'b0010) begin errors++; $display("FAIL pp_req req=%b expected=0010", req_o); end
        step(); gnt_man = '0; drive_push(4'b0010, 32'h00006300, 4'b0010);
        @(negedge clk);
        checks++;
        if (full_o !== 4'b0000) begin errors++; $display("FAIL pp_count2 full=%b expected=0000", full_o); end
        step(); drive_push(4'b0010, 32'h00006400, 4'b0010);
        @(negedge clk);
        checks++;
        if (full_o !== 4'b0000) begin errors++; $display("FAIL pp_count3 full=%b expected=0000", full_o); end
        step(); push_i = '0;
        @(negedge clk);
        checks++;
        if (full_o !== 4'b0010) begin errors++; $display("FAIL pp_count4 full=%b expected=0010", full_o); end
        // Push into a full port while popping it: the push is still dropped.
        step(); drive_push(4'b0010, 32'h00006500, 4'b0000); gnt_man = 4'b0010;
        step(); push_i = '0; gnt_man = '0;
        @(negedge clk);
        checks++;
        if (ovf_o !== 4'b0010 || full_o !== 4'b0000 || out_valid_o !== 1'b1) begin
            errors++; $display("FAIL pp_fullpop ovf=%b full=%b valid=%b expected=0010/0000/1", ovf_o, full_o, out_valid_o);
        end
        mode = 1; gnt_mask = 4'b0010;
        wait_drain("pp", 30);
    endtask

    initial begin
        xfer_cnt = 0;
        test_reset();
        test_single();
        test_full_ovf();
        test_backpressure();
        test_illegal_and_reset();
        test_round_robin();
        test_push_pop_same();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
